act_quant_unit: RTL
===================

# act_quant_unit

Pipelined, multi-channel activation and requantisation stage placed between the PE array partial-sum output and the output feature-map buffer. It accepts CH signed partial sums per beat, applies a runtime-selected activation (bypass, ReLU, leaky ReLU, clipped ReLU), rounds and shifts to the output precision, and saturates. It uses valid/ready handshakes on both sides and keeps a saturation event counter for quantisation tuning.

## Interface
- PSUM_WID, 24, signed partial-sum width per lane
- OUT_WID, 8, signed output width per lane
- CH, 4, lanes per beat
- SAT_CNT_WID, 16, saturation counter width

Ports. Reset is asynchronous and active-high. One clock.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  CH*PSUM_WID  lane i at [i*PSUM_WID +: PSUM_WID], signed
- cfg_mode  in  2  00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU
- cfg_leak_shift  in  3  negative-slope shift for leaky ReLU
- cfg_shift  in  5  requantisation right shift, 0..PSUM_WID-1
- cfg_clip  in  OUT_WID-1  unsigned upper bound for clipped ReLU
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  CH*OUT_WID  lane i at [i*OUT_WID +: OUT_WID], signed
- sat_clr  in  1  synchronous clear of sat_cnt
- sat_cnt  out  SAT_CNT_WID  saturating count of saturated lanes

## Operation
- Config is sampled on the input handshake and travels with its beat. Config changes never affect beats already in flight.
- Stage 1 (activation, per lane x):
  - bypass: x
  - ReLU and clipped ReLU: x<0 ? 0 : x
  - leaky ReLU: x<0 ? x>>>cfg_leak_shift (arithmetic, floor) : x
- Stage 2 (requantisation, per lane a):
  - If shift==0, r=a. Otherwise r=(a + 2^(shift-1))>>>shift, computed in PSUM_WID+1 bits (round half up).
  - r is saturated to [-2^(OUT_WID-1), 2^(OUT_WID-1)-1]. Each lane that is clamped here counts as one saturation event.
  - Clipped ReLU then clamps to [0, cfg_clip]. This clamp is not a saturation event.
- sat_cnt:
  - Adds the number of saturated lanes of a beat (0..CH) on that beat's output handshake.
  - Sticks at all-ones.
  - sat_clr has priority; the concurrent beat's count is dropped.

## Timing
- Two register stages with valid bits v1 and v2.
  - en2 = !v2 || out_ready
  - en1 = !v1 || en2
  - in_ready = en1 (combinational)
- Latency: a beat accepted at edge N is presented on out_data with out_valid=1 after edge N+2 when there is no stall.
- Throughput is one beat per cycle.
- Stall: while out_ready=0, out_data and out_valid stay stable. With both stages full, in_ready=0. No beat is lost, duplicated or reordered.
- Reset values: v1=v2=0, out_valid=0, out_data=0, sat_cnt=0, all pipeline data registers 0. in_ready=1 while rst is high.
- Reset mid-stream discards in-flight beats immediately.
- shift=0 means no rounding term. leak_shift=0 makes leaky ReLU behave as bypass.

## Structure
- Shared package/defines file holds the mode encodings (MODE_BYPASS, MODE_RELU, MODE_LEAKY, MODE_CLIP) and the default PSUM_WID/OUT_WID. It reuses the existing psum width define.
- One sub-module, act_quant_lane: a combinational per-lane activation, round, saturate and clip function with a sat flag output. It is instantiated CH times across the two stages, split at the stage-1 register.
- The top level holds the elastic pipeline control, the config side-band registers and the sat counter.

## Test plan
Defaults: PSUM_WID=24, OUT_WID=8, CH=4, lanes listed 0..3.
- Reset: assert rst with v1 and v2 full -> out_valid=0, out_data=0, sat_cnt=0 immediately; in_ready=1; no stale beat appears after release.
- ReLU, shift 0, in {5,-8,6985,-5487} -> out {5,0,127,0} two cycles later; sat_cnt=1.
- Leaky, leak_shift 3, shift 2, in {40,-8,-8745,6} -> out {10,0,-128,2}; sat_cnt +1.
- Clipped ReLU, clip 6, shift 4, in {100,200,-50,50} -> out {6,6,0,3}; sat_cnt unchanged.
- Backpressure: stream 6 distinct beats with out_ready held 0 for 5 cycles -> in_ready falls after 2 accepts; after release all 6 beats emerge in order, one per cycle, with no duplicates.
- Counter: sat_clr asserted in the same cycle as a saturating output handshake -> sat_cnt=0. Preload the counter near all-ones, then send saturating beats -> sat_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/act_quant_unit_pkg.sv
// Shared definitions for the activation/requantisation stage: activation mode
// encodings and default datapath widths.
package act_quant_unit_pkg;

  localparam int PSUM_WID_DEF = 24;
  localparam int OUT_WID_DEF  = 8;
  localparam int CH_DEF       = 4;
  localparam int SAT_CNT_DEF  = 16;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_RELU   = 2'b01,
    MODE_LEAKY  = 2'b10,
    MODE_CLIP   = 2'b11
  } act_mode_e;

endpackage

// File: rtl/act_quant_lane.sv
// Combinational per-lane datapath. The activation half feeds the stage-1
// register; the round/saturate/clip half reads it back and feeds stage 2.
module act_quant_lane
  import act_quant_unit_pkg::*;
#(
  parameter int PSUM_WID = PSUM_WID_DEF,
  parameter int OUT_WID  = OUT_WID_DEF
) (
  input  logic [1:0]          act_mode_i,
  input  logic [2:0]          leak_shift_i,
  input  logic [PSUM_WID-1:0] x_i,
  output logic [PSUM_WID-1:0] act_o,
  input  logic [1:0]          q_mode_i,
  input  logic [4:0]          shift_i,
  input  logic [OUT_WID-2:0]  clip_i,
  input  logic [PSUM_WID-1:0] a_i,
  output logic [OUT_WID-1:0]  q_o,
  output logic                sat_o
);

  // One guard bit so the rounding add cannot overflow.
  localparam int EW = PSUM_WID + 1;
  localparam logic signed [EW-1:0] SAT_MAX = EW'(2**(OUT_WID-1) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [EW-1:0] ONE     = EW'(1);

  logic signed [PSUM_WID-1:0] x_s;
  logic signed [EW-1:0]       a_ext;
  logic signed [EW-1:0]       rnd;
  logic signed [EW-1:0]       r;
  logic [OUT_WID-1:0]         sat_val;

  assign x_s = x_i;

  always_comb begin
    act_o = x_i;
    if (x_i[PSUM_WID-1]) begin
      case (act_mode_i)
        MODE_RELU, MODE_CLIP: act_o = '0;
        MODE_LEAKY:           act_o = x_s >>> leak_shift_i;
        default:              act_o = x_i;
      endcase
    end
  end

  always_comb begin
    a_ext = {a_i[PSUM_WID-1], a_i};
    rnd   = '0;
    if (shift_i != 5'd0) begin
      rnd = ONE <<< (shift_i - 5'd1);
    end
    r = (a_ext + rnd) >>> shift_i;

    sat_o   = 1'b0;
    sat_val = r[OUT_WID-1:0];
    if (r > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_WID-1:0];
      sat_o   = 1'b1;
    end else if (r < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_WID-1:0];
      sat_o   = 1'b1;
    end

    // The clip bound is a range limit, not a saturation event.
    q_o = sat_val;
    if (q_mode_i == MODE_CLIP) begin
      if (sat_val[OUT_WID-1]) begin
        q_o = '0;
      end else if (sat_val[OUT_WID-2:0] > clip_i) begin
        q_o = {1'b0, clip_i};
      end
    end
  end

endmodule

// File: rtl/act_quant_unit.sv
// Two-stage elastic activation/requantisation pipeline with per-beat config
// side-band and a sticky saturation event counter.
module act_quant_unit
  import act_quant_unit_pkg::*;
#(
  parameter int PSUM_WID    = PSUM_WID_DEF,
  parameter int OUT_WID     = OUT_WID_DEF,
  parameter int CH          = CH_DEF,
  parameter int SAT_CNT_WID = SAT_CNT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH*PSUM_WID-1:0]  in_data,
  input  logic [1:0]              cfg_mode,
  input  logic [2:0]              cfg_leak_shift,
  input  logic [4:0]              cfg_shift,
  input  logic [OUT_WID-2:0]      cfg_clip,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH*OUT_WID-1:0]   out_data,
  input  logic                    sat_clr,
  output logic [SAT_CNT_WID-1:0]  sat_cnt
);

  localparam int CNT_W = $clog2(CH + 1);

  logic                   en1;
  logic                   en2;
  logic                   v1_q;
  logic                   v2_q;
  logic [CH*PSUM_WID-1:0] act_d;
  logic [CH*PSUM_WID-1:0] act_q;
  logic [1:0]             mode1_q;
  logic [4:0]             shift1_q;
  logic [OUT_WID-2:0]     clip1_q;
  logic [CH*OUT_WID-1:0]  q_d;
  logic [CH*OUT_WID-1:0]  out_q;
  logic [CH-1:0]          sat_lane;
  logic [CNT_W-1:0]       nsat_d;
  logic [CNT_W-1:0]       nsat2_q;
  logic [SAT_CNT_WID:0]   cnt_sum;
  logic [SAT_CNT_WID-1:0] sat_cnt_d;
  logic [SAT_CNT_WID-1:0] sat_cnt_q;

  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      act_quant_lane #(
        .PSUM_WID (PSUM_WID),
        .OUT_WID  (OUT_WID)
      ) u_lane (
        .act_mode_i   (cfg_mode),
        .leak_shift_i (cfg_leak_shift),
        .x_i          (in_data[gi*PSUM_WID +: PSUM_WID]),
        .act_o        (act_d[gi*PSUM_WID +: PSUM_WID]),
        .q_mode_i     (mode1_q),
        .shift_i      (shift1_q),
        .clip_i       (clip1_q),
        .a_i          (act_q[gi*PSUM_WID +: PSUM_WID]),
        .q_o          (q_d[gi*OUT_WID +: OUT_WID]),
        .sat_o        (sat_lane[gi])
      );
    end
  endgenerate

  always_comb begin
    nsat_d = '0;
    for (int i = 0; i < CH; i++) begin
      nsat_d = nsat_d + CNT_W'(sat_lane[i]);
    end
  end

  // Stage 1 carries the activated lanes plus the config stage 2 still needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      act_q    <= '0;
      mode1_q  <= '0;
      shift1_q <= '0;
      clip1_q  <= '0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        act_q    <= act_d;
        mode1_q  <= cfg_mode;
        shift1_q <= cfg_shift;
        clip1_q  <= cfg_clip;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      out_q   <= '0;
      nsat2_q <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        out_q   <= q_d;
        nsat2_q <= nsat_d;
      end
    end
  end

  // Counter sticks at all-ones; a clear wins over a same-cycle increment.
  always_comb begin
    cnt_sum   = {1'b0, sat_cnt_q} + (SAT_CNT_WID+1)'(nsat2_q);
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (v2_q && out_ready) begin
      sat_cnt_d = cnt_sum[SAT_CNT_WID] ? '1 : cnt_sum[SAT_CNT_WID-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = out_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
